data_mem_arbiter: RTL and testbench

Two-core request arbiter sitting directly upstream of the shared data memory (DataMEM). Each core presents load/store requests with a req/ack handshake. The arbiter grants one request per cycle using round-robin priority and drives a single registered command onto the memory port. It then routes the returned read data back to the requesting core with a valid pulse. Out-of-range addresses are filtered and flagged, so the memory never sees an illegal access.

---
 rtl/data_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-core round-robin arbiter in front of the shared data memory.
// It issues one registered command per cycle, drops out-of-range accesses
// (raising a sticky flag) and steers the read data back to the requesting core.
module data_mem_arbiter #(
  parameter int unsigned TAM  = 16,
  parameter int unsigned Lmem = 8
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           coreREQ0,
  input  logic           coreWE0,
  input  logic [TAM-1:0] coreADDR0,
  input  logic [TAM-1:0] coreDATA0,
  output logic           coreACK0,
  output logic [TAM-1:0] coreRDATA0,
  output logic           coreRVALID0,

  input  logic           coreREQ1,
  input  logic           coreWE1,
  input  logic [TAM-1:0] coreADDR1,
  input  logic [TAM-1:0] coreDATA1,
  output logic           coreACK1,
  output logic [TAM-1:0] coreRDATA1,
  output logic           coreRVALID1,

  output logic [TAM-1:0] memADDR,
  output logic [TAM-1:0] memDATAIN,
  output logic           memWrite,
  output logic           memLoad,
  input  logic [TAM-1:0] memDATAOUT,

  output logic           errOOR
);

  // One read-return tag: which core asked and whether the access was legal.
  typedef struct packed {
    logic valid;
    logic core;
    logic inr;
  } tag_t;

  // Round-robin pointer: core that wins when both request.
  logic prio_q, prio_d;

  // Arbitration results.
  logic           ack0, ack1;
  logic           accept;
  logic           gnt_core;
  logic           sel_we;
  logic [TAM-1:0] sel_addr;
  logic [TAM-1:0] sel_data;
  logic           in_range;

  // Command register.
  logic [TAM-1:0] addr_q, addr_d;
  logic [TAM-1:0] wdata_q, wdata_d;
  logic           write_q, write_d;
  logic           load_q, load_d;

  // Sticky out-of-range flag.
  logic err_q, err_d;

  // Read-return tag pipeline, aligned with the memory's one-cycle read latency.
  tag_t s1_q, s1_d;
  tag_t s2_q, s2_d;

  // Last delivered read data per core.
  logic [TAM-1:0] rdata0_q, rdata0_d;
  logic [TAM-1:0] rdata1_q, rdata1_d;
  logic           ret_v0, ret_v1;
  logic [TAM-1:0] ret_data;

  // Grant selection; acks are forced low while reset is asserted.
  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (rst) begin
      if (coreREQ0 && coreREQ1) begin
        ack0 = ~prio_q;
        ack1 = prio_q;
      end else begin
        ack0 = coreREQ0;
        ack1 = coreREQ1;
      end
    end
  end

  assign coreACK0 = ack0;
  assign coreACK1 = ack1;
  assign accept   = ack0 | ack1;
  assign gnt_core = ack1;

  // Mux the granted core's request and range-check its address.
  always_comb begin
    sel_we   = gnt_core ? coreWE1   : coreWE0;
    sel_addr = gnt_core ? coreADDR1 : coreADDR0;
    sel_data = gnt_core ? coreDATA1 : coreDATA0;
    in_range = ((sel_addr >> Lmem) == '0);
  end

  // Next state for pointer, command register and error flag.
  always_comb begin
    prio_d  = prio_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    load_d  = 1'b0;
    err_d   = err_q;
    if (accept) begin
      prio_d  = ~gnt_core;
      addr_d  = sel_addr;
      wdata_d = sel_data;
      write_d = sel_we & in_range;
      load_d  = ~sel_we & in_range;
      if (!in_range) begin
        err_d = 1'b1;
      end
    end
  end

  // Tag pipeline advance; only loads (legal or not) produce a return.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = accept & ~sel_we;
    s1_d.core  = gnt_core;
    s1_d.inr   = in_range;
    s2_d       = s1_q;
  end

  // Read return steering; an illegal load returns zero instead of memory data.
  always_comb begin
    ret_v0   = s2_q.valid & ~s2_q.core;
    ret_v1   = s2_q.valid & s2_q.core;
    ret_data = s2_q.inr ? memDATAOUT : '0;
    rdata0_d = ret_v0 ? ret_data : rdata0_q;
    rdata1_d = ret_v1 ? ret_data : rdata1_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      prio_q   <= prio_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      load_q   <= load_d;
      err_q    <= err_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign memADDR     = addr_q;
  assign memDATAIN   = wdata_q;
  assign memWrite    = write_q;
  assign memLoad     = load_q;
  assign errOOR      = err_q;
  assign coreRVALID0 = ret_v0;
  assign coreRVALID1 = ret_v1;
  // The pulse cycle shows live memory data; otherwise the held value.
  assign coreRDATA0  = rdata0_d;
  assign coreRDATA1  = rdata1_d;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a transaction-level model
// (grant rule, shadow memory, queue of due read returns) checked every cycle,
// plus directed literal checks from the test plan.
module tb_data_mem_arbiter;

  localparam int TAM  = 16;
  localparam int LMEM = 8;

  logic           clk;
  logic           rst;
  logic           req0, we0, req1, we1;
  logic [TAM-1:0] addr0, data0, addr1, data1;
  logic           ack0, ack1, rv0, rv1;
  logic [TAM-1:0] rdata0, rdata1;
  logic [TAM-1:0] mem_addr, mem_din, mem_dout;
  logic           mem_wr, mem_ld, err;

  data_mem_arbiter #(.TAM(TAM), .Lmem(LMEM)) dut (
    .clk        (clk),
    .rst        (rst),
    .coreREQ0   (req0),
    .coreWE0    (we0),
    .coreADDR0  (addr0),
    .coreDATA0  (data0),
    .coreACK0   (ack0),
    .coreRDATA0 (rdata0),
    .coreRVALID0(rv0),
    .coreREQ1   (req1),
    .coreWE1    (we1),
    .coreADDR1  (addr1),
    .coreDATA1  (data1),
    .coreACK1   (ack1),
    .coreRDATA1 (rdata1),
    .coreRVALID1(rv1),
    .memADDR    (mem_addr),
    .memDATAIN  (mem_din),
    .memWrite   (mem_wr),
    .memLoad    (mem_ld),
    .memDATAOUT (mem_dout),
    .errOOR     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DataMEM: synchronous write, one-cycle registered read.
  logic [TAM-1:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:0]] <= mem_din;
    if (mem_ld) mem_dout <= mem[mem_addr[7:0]];
  end

  // ---------------- model ----------------
  typedef struct packed {
    logic [31:0]    due;
    logic           core;
    logic [TAM-1:0] data;
  } ret_t;

  ret_t           q[$];
  logic [TAM-1:0] shadow [0:255];
  logic           m_prio, m_wr, m_ld, m_err;
  logic [TAM-1:0] m_addr, m_data;
  logic [TAM-1:0] m_rdata [0:1];
  int             cyc;
  int             tests, fails;

  // Observed values of the last checked cycle, for directed literal checks.
  logic           o_ack0, o_ack1, o_rv0, o_rv1, o_wr, o_ld, o_err;
  logic [TAM-1:0] o_rd0, o_rd1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prio     = 1'b0;
    m_wr       = 1'b0;
    m_ld       = 1'b0;
    m_err      = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    q.delete();
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model
  // by whatever gets accepted at the next rising edge.
  task automatic step();
    logic           e_ack0, e_ack1, g, we, inr;
    logic [1:0]     e_rv;
    logic [TAM-1:0] a, d;
    @(negedge clk);
    if (!rst) model_reset();
    e_ack0 = 1'b0;
    e_ack1 = 1'b0;
    if (rst) begin
      if (req0 && req1) begin
        e_ack0 = (m_prio == 1'b0);
        e_ack1 = (m_prio == 1'b1);
      end else begin
        e_ack0 = req0;
        e_ack1 = req1;
      end
    end
    e_rv = 2'b00;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_rv[q[0].core]     = 1'b1;
      m_rdata[q[0].core]  = q[0].data;
      void'(q.pop_front());
    end
    chk("ack0", {31'd0, ack0}, {31'd0, e_ack0});
    chk("ack1", {31'd0, ack1}, {31'd0, e_ack1});
    chk("memWrite", {31'd0, mem_wr}, {31'd0, m_wr});
    chk("memLoad", {31'd0, mem_ld}, {31'd0, m_ld});
    chk("memADDR", {16'd0, mem_addr}, {16'd0, m_addr});
    chk("memDATAIN", {16'd0, mem_din}, {16'd0, m_data});
    chk("errOOR", {31'd0, err}, {31'd0, m_err});
    chk("rvalid0", {31'd0, rv0}, {31'd0, e_rv[0]});
    chk("rvalid1", {31'd0, rv1}, {31'd0, e_rv[1]});
    chk("rdata0", {16'd0, rdata0}, {16'd0, m_rdata[0]});
    chk("rdata1", {16'd0, rdata1}, {16'd0, m_rdata[1]});
    o_ack0 = ack0; o_ack1 = ack1; o_rv0 = rv0; o_rv1 = rv1;
    o_wr = mem_wr; o_ld = mem_ld; o_err = err; o_rd0 = rdata0; o_rd1 = rdata1;
    if (rst) begin
      if (e_ack0 || e_ack1) begin
        g   = e_ack1;
        we  = g ? we1 : we0;
        a   = g ? addr1 : addr0;
        d   = g ? data1 : data0;
        inr = ((a >> LMEM) == '0);
        m_addr = a;
        m_data = d;
        m_wr   = we & inr;
        m_ld   = ~we & inr;
        if (!inr) m_err = 1'b1;
        if (!we) q.push_back('{due: cyc + 2, core: g, data: (inr ? shadow[a[7:0]] : '0)});
        else if (inr) shadow[a[7:0]] = d;
        m_prio = ~g;
      end else begin
        m_wr = 1'b0;
        m_ld = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int core, input logic req, input logic we,
                       input logic [TAM-1:0] a, input logic [TAM-1:0] d);
    if (core == 0) begin
      req0 = req; we0 = we; addr0 = a; data0 = d;
    end else begin
      req1 = req; we1 = we; addr1 = a; data1 = d;
    end
  endtask

  int n0, n1, nboth;

  initial begin
    tests = 0; fails = 0; cyc = 0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    model_reset();
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
    drive(1, 1'b1, 1'b0, 16'h0020, 16'h0000);

    // Reset held with both requests up: nothing acked.
    repeat (3) step();
    chk("rst_ack0", {31'd0, o_ack0}, 32'd0);
    chk("rst_ack1", {31'd0, o_ack1}, 32'd0);

    // Release: core 0 wins first; its store strobes the next cycle.
    rst = 1'b1;
    step();
    chk("first_ack0", {31'd0, o_ack0}, 32'd1);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("store_memWrite", {31'd0, o_wr}, 32'd1);
    chk("loser_ack1", {31'd0, o_ack1}, 32'd1);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Load back 0x0005 on core 0: returns two cycles after accept.
    drive(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("load_memLoad", {31'd0, o_ld}, 32'd1);
    step();
    chk("load_rvalid0", {31'd0, o_rv0}, 32'd1);
    chk("load_rdata0", {16'd0, o_rd0}, 32'h0000_BEEF);
    step();

    // Contention for 10 cycles: strict alternation.
    n0 = 0; n1 = 0; nboth = 0;
    drive(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    drive(1, 1'b1, 1'b0, 16'h0031, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ack0) n0++;
      if (o_ack1) n1++;
      if (o_ack0 && o_ack1) nboth++;
    end
    chk("cont_grants0", n0, 32'd5);
    chk("cont_grants1", n1, 32'd5);
    chk("cont_both", nboth, 32'd0);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) step();

    // Preload 0x10/0x11, then pipelined loads from alternating cores.
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h1111);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b1, 1'b1, 16'h0011, 16'h2222);
    step();
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    step();
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("pipe_rvalid0", {31'd0, o_rv0}, 32'd1);
    chk("pipe_rdata0", {16'd0, o_rd0}, 32'h0000_1111);
    step();
    chk("pipe_rvalid1", {31'd0, o_rv1}, 32'd1);
    chk("pipe_rdata1", {16'd0, o_rd1}, 32'h0000_2222);
    chk("pipe_rdata0_hold", {16'd0, o_rd0}, 32'h0000_1111);
    step();

    // Out-of-range load on core 1.
    drive(1, 1'b1, 1'b0, 16'h0100, 16'h0000);
    step();
    chk("oor_ack1", {31'd0, o_ack1}, 32'd1);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("oor_memLoad", {31'd0, o_ld}, 32'd0);
    chk("oor_err", {31'd0, o_err}, 32'd1);
    step();
    chk("oor_rvalid1", {31'd0, o_rv1}, 32'd1);
    chk("oor_rdata1", {16'd0, o_rd1}, 32'h0000_0000);
    drive(0, 1'b1, 1'b1, 16'h0007, 16'h00AA);
    step();
    drive(0, 1'b1, 1'b0, 16'h0007, 16'h0000);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) step();
    chk("oor_err_sticky", {31'd0, o_err}, 32'd1);

    // Reset one cycle after a core 0 load is accepted (pointer then at core 1).
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    step();
    chk("mid_rst_err", {31'd0, o_err}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_rvalid0_a", {31'd0, o_rv0}, 32'd0);
    step();
    chk("mid_rst_rvalid0_b", {31'd0, o_rv0}, 32'd0);
    drive(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
    drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    chk("mid_rst_prio", {31'd0, o_ack0}, 32'd1);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
